ram_sdp_be: RTL and testbench

- Parametrised simple-dual-port RAM: one write port with byte enables, one read port with registered output.
- Built-in clear engine fills every word with INIT_VALUE after reset and on request.
- Configurable read-during-write behaviour.
- Serves as the general data/stack memory for the CPU, replacing fixed-size single-port storage with combinational read.

---
 rtl/ram_sdp_be.sv | 164 ++++++++++++++++
 tb/tb_ram_sdp_be.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/ram_sdp_be.sv
// ram_sdp_be: simple-dual-port RAM with a byte-enabled write port, a registered
// read port and a built-in clear engine. After reset, and whenever clear is
// pulsed while idle, every word is filled with INIT_VALUE one word per cycle.
// While the clear engine runs, busy is high and all accesses are ignored.
// A same-address read during a write returns either the old word or the
// byte-merged new word, depending on RDW_NEW.

module ram_sdp_be #(
    parameter int               WIDTH      = 16,
    parameter int               DEPTH      = 16,
    parameter logic [WIDTH-1:0] INIT_VALUE = '0,
    parameter bit               RDW_NEW    = 1'b0,
    localparam int              AW         = $clog2(DEPTH),
    localparam int              NB         = WIDTH / 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    output logic             busy,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [NB-1:0]    wr_be,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data,
    output logic             rd_valid
);

    // One extra bit lets addresses be compared against DEPTH even when
    // DEPTH is an exact power of two.
    localparam logic [AW:0]   DEPTH_W  = (AW + 1)'(DEPTH);
    localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } state_t;

    state_t           state_r;
    logic [AW-1:0]    ptr_r;
    logic             busy_r;
    logic [WIDTH-1:0] rd_data_r;
    logic             rd_valid_r;
    logic [WIDTH-1:0] mem_r [DEPTH];

    logic             idle_s;
    logic             wr_in_range_s;
    logic             rd_in_range_s;
    logic             wr_fire_s;
    logic             rd_fire_s;
    logic             rdw_hit_s;
    logic [WIDTH-1:0] rd_old_s;
    logic [WIDTH-1:0] rd_next_s;

    // Replace the lanes of old_w selected by be with the matching lanes of new_w.
    function automatic logic [WIDTH-1:0] merge_bytes(
        input logic [WIDTH-1:0] old_w,
        input logic [WIDTH-1:0] new_w,
        input logic [NB-1:0]    be
    );
        logic [WIDTH-1:0] res;
        res = old_w;
        for (int i = 0; i < NB; i++) begin
            if (be[i]) begin
                res[8*i +: 8] = new_w[8*i +: 8];
            end
        end
        return res;
    endfunction

    assign idle_s        = (state_r == ST_IDLE);
    assign wr_in_range_s = ({1'b0, wr_addr} < DEPTH_W);
    assign rd_in_range_s = ({1'b0, rd_addr} < DEPTH_W);
    assign wr_fire_s     = idle_s && wr_en && wr_in_range_s && (wr_be != '0);
    assign rd_fire_s     = idle_s && rd_en;
    assign rdw_hit_s     = wr_fire_s && (wr_addr == rd_addr);

    // Clear-engine state machine: walks ptr over every word, then idles until clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_CLEAR;
            ptr_r   <= '0;
            busy_r  <= 1'b1;
        end else begin
            case (state_r)
                ST_CLEAR: begin
                    if (ptr_r == LAST_PTR) begin
                        state_r <= ST_IDLE;
                        ptr_r   <= '0;
                        busy_r  <= 1'b0;
                    end else begin
                        ptr_r   <= ptr_r + AW'(1'b1);
                    end
                end
                ST_IDLE: begin
                    if (clear) begin
                        state_r <= ST_CLEAR;
                        ptr_r   <= '0;
                        busy_r  <= 1'b1;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                default: begin
                    state_r <= ST_CLEAR;
                    ptr_r   <= '0;
                    busy_r  <= 1'b1;
                end
            endcase
        end
    end

    // Storage array: clear-engine fill has priority; otherwise byte-lane writes.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (state_r == ST_CLEAR) begin
                mem_r[ptr_r] <= INIT_VALUE;
            end else if (wr_fire_s) begin
                for (int i = 0; i < NB; i++) begin
                    if (wr_be[i]) begin
                        mem_r[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
                    end
                end
            end
        end
    end

    // Next read word: zero when out of range, optionally forwarding same-cycle write lanes.
    always_comb begin
        rd_old_s  = '0;
        rd_next_s = '0;
        if (rd_in_range_s) begin
            rd_old_s = mem_r[rd_addr];
        end else begin
            rd_old_s = '0;
        end
        if (!rd_in_range_s) begin
            rd_next_s = '0;
        end else if (RDW_NEW && rdw_hit_s) begin
            rd_next_s = merge_bytes(rd_old_s, wr_data, wr_be);
        end else begin
            rd_next_s = rd_old_s;
        end
    end

    // Registered read port: capture on a serviced read, pulse valid for one cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data_r  <= '0;
            rd_valid_r <= 1'b0;
        end else if (rd_fire_s) begin
            rd_data_r  <= rd_next_s;
            rd_valid_r <= 1'b1;
        end else begin
            rd_valid_r <= 1'b0;
        end
    end

    assign busy     = busy_r;
    assign rd_data  = rd_data_r;
    assign rd_valid = rd_valid_r;

endmodule

// File: tb/tb_ram_sdp_be.sv
// Scoreboard bench for ram_sdp_be. Two instances share one stimulus stream:
//   dut_a: DEPTH=16, RDW_NEW=0 (old data on read-during-write)
//   dut_b: DEPTH=15, RDW_NEW=1 (new byte-merged data, address 15 out of range)
// Read expectations are pushed per instance at issue time; a monitor pops
// and compares whenever rd_valid is seen.

module tb_ram_sdp_be;

    localparam logic [15:0] INIT = 16'hA5A5;

    logic        clk = 1'b0;
    logic        reset;
    logic        clear;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [15:0] wr_data;
    logic [1:0]  wr_be;
    logic        rd_en;
    logic [3:0]  rd_addr;

    logic        busy_a, rd_valid_a;
    logic [15:0] rd_data_a;
    logic        busy_b, rd_valid_b;
    logic [15:0] rd_data_b;

    logic [15:0] qa [$];
    logic [15:0] qb [$];

    int vectors     = 0;
    int miscompares = 0;
    int na, nb;

    always #5 clk = ~clk;

    ram_sdp_be #(.WIDTH(16), .DEPTH(16), .INIT_VALUE(INIT), .RDW_NEW(1'b0)) dut_a (
        .clk(clk), .reset(reset), .clear(clear), .busy(busy_a),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_a), .rd_valid(rd_valid_a)
    );

    ram_sdp_be #(.WIDTH(16), .DEPTH(15), .INIT_VALUE(INIT), .RDW_NEW(1'b1)) dut_b (
        .clk(clk), .reset(reset), .clear(clear), .busy(busy_b),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_b), .rd_valid(rd_valid_b)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [3:0] a, input logic [15:0] d, input logic [1:0] be);
        wr_en = 1'b1; wr_addr = a; wr_data = d; wr_be = be;
        cyc();
        wr_en = 1'b0;
    endtask

    task automatic rd(input logic [3:0] a, input logic [15:0] ea, input logic [15:0] eb);
        rd_en = 1'b1; rd_addr = a;
        qa.push_back(ea);
        qb.push_back(eb);
        cyc();
        rd_en = 1'b0;
    endtask

    // Back-to-back sweep of every address; dut_b sees address 15 as out of range.
    task automatic rd_all();
        for (int i = 0; i < 16; i++) begin
            rd_en = 1'b1; rd_addr = 4'(i);
            qa.push_back(INIT);
            qb.push_back((i == 15) ? 16'h0000 : INIT);
            cyc();
        end
        rd_en = 1'b0;
        cyc();
    endtask

    task automatic busy_wait(output int ca, output int cb);
        ca = 0; cb = 0;
        for (int n = 0; n < 200 && (busy_a || busy_b); n++) begin
            if (busy_a) ca++;
            if (busy_b) cb++;
            cyc();
        end
    endtask

    // Monitor: every rd_valid pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rd_valid_a === 1'b1) begin
            if (qa.size() == 0) begin
                chk("a_unexpected_valid", 32'd1, 32'd0);
            end else begin
                chk("a_rd_data", {16'h0, rd_data_a}, {16'h0, qa.pop_front()});
            end
        end
        if (rd_valid_b === 1'b1) begin
            if (qb.size() == 0) begin
                chk("b_unexpected_valid", 32'd1, 32'd0);
            end else begin
                chk("b_rd_data", {16'h0, rd_data_b}, {16'h0, qb.pop_front()});
            end
        end
    end

    initial begin
        reset = 1'b1; clear = 1'b0; wr_en = 1'b0; wr_addr = 4'h0; wr_data = 16'h0000;
        wr_be = 2'b00; rd_en = 1'b0; rd_addr = 4'h0;
        repeat (3) cyc();
        chk("rst_busy_a", {31'h0, busy_a}, 32'd1);
        chk("rst_busy_b", {31'h0, busy_b}, 32'd1);
        chk("rst_valid_a", {31'h0, rd_valid_a}, 32'd0);
        chk("rst_data_a", {16'h0, rd_data_a}, 32'd0);
        chk("rst_data_b", {16'h0, rd_data_b}, 32'd0);

        // Initial clear after reset release
        reset = 1'b0;
        busy_wait(na, nb);
        chk("init_busy_len_a", 32'(na), 32'd16);
        chk("init_busy_len_b", 32'(nb), 32'd15);
        rd_all();

        // Byte enables
        wr(4'd3, 16'h1234, 2'b11);
        wr(4'd3, 16'hABCD, 2'b01);
        rd(4'd3, 16'h12CD, 16'h12CD);

        // Read-during-write on address 5
        wr(4'd5, 16'h0000, 2'b11);
        wr_en = 1'b1; wr_addr = 4'd5; wr_data = 16'hBEEF; wr_be = 2'b10;
        rd_en = 1'b1; rd_addr = 4'd5;
        qa.push_back(16'h0000);
        qb.push_back(16'hBE00);
        cyc();
        wr_en = 1'b0; rd_en = 1'b0;
        rd(4'd5, 16'hBE00, 16'hBE00);

        // Zero byte enable and out-of-range address
        wr(4'd14, 16'h1111, 2'b00);
        rd(4'd14, INIT, INIT);
        wr(4'd15, 16'hFFFF, 2'b11);
        rd(4'd15, 16'hFFFF, 16'h0000);

        // Clear mid-run; a read in the clear cycle is still serviced
        wr(4'd7, 16'h5555, 2'b11);
        clear = 1'b1; rd_en = 1'b1; rd_addr = 4'd7;
        qa.push_back(16'h5555);
        qb.push_back(16'h5555);
        cyc();
        clear = 1'b0; rd_en = 1'b0;
        na = 0; nb = 0;
        for (int n = 0; n < 200 && (busy_a || busy_b); n++) begin
            wr_en = (n == 0); wr_addr = 4'd2; wr_data = 16'h7777; wr_be = 2'b11;
            rd_en = (n < 4); rd_addr = 4'd7;
            if (busy_a) na++;
            if (busy_b) nb++;
            cyc();
        end
        wr_en = 1'b0; rd_en = 1'b0;
        chk("clr_busy_len_a", 32'(na), 32'd16);
        chk("clr_busy_len_b", 32'(nb), 32'd15);
        rd(4'd7, INIT, INIT);
        rd(4'd2, INIT, INIT);
        rd(4'd15, INIT, 16'h0000);

        // Reset during the clear sweep restarts it from address 0
        wr(4'd9, 16'h9999, 2'b11);
        clear = 1'b1;
        cyc();
        clear = 1'b0;
        repeat (4) cyc();
        reset = 1'b1;
        cyc();
        cyc();
        chk("midrst_busy_a", {31'h0, busy_a}, 32'd1);
        chk("midrst_busy_b", {31'h0, busy_b}, 32'd1);
        reset = 1'b0;
        busy_wait(na, nb);
        chk("midrst_busy_len_a", 32'(na), 32'd16);
        chk("midrst_busy_len_b", 32'(nb), 32'd15);
        rd_all();

        repeat (3) cyc();
        chk("qa_drained", 32'(qa.size()), 32'd0);
        chk("qb_drained", 32'(qb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
